rv32im_decoder_cu: RTL and testbench
====================================

RV32IM_DECODER_CU -- requirements
Module: rv32im_decoder_cu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port instruction, input, 32 bits: RV32IM instruction word.
REQ-004 SHALL have outputs data_origin_o[1:0], data_target_o[1:0], imm_o[31:0], rs1_addr_o[4:0], rs2_addr_o[4:0] and rd_addr_o[4:0].
REQ-005 SHALL have outputs alu_opcode_o[4:0], lsu_opcode_o[7:0], br_opcode_o[2:0], is_branch_o, is_condition_o, csr_opcode_o[2:0], csr_addr_o[11:0], csr_data_o[31:0], mem_w_o and reg_w_o.

Function
REQ-006 SHALL register all outputs on the rising clk edge; decode latency is 1 cycle.
REQ-007 SHALL drive rs1/rs2/rd addresses from instruction[19:15]/[24:20]/[11:7] for every format.
REQ-008 SHALL build imm_o per format: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0); all except U sign-extended from instruction[31]; R-type imm = 0.
REQ-009 SHALL encode data_origin_o as: 00 = rs1,rs2; 01 = rs1,imm; 10 = pc,imm; 11 = csr.
REQ-010 SHALL encode data_target_o as: 00 = none; 01 = rd<-ALU; 10 = rd<-load data; 11 = rd<-pc+4.
REQ-011 SHALL encode alu_opcode_o as: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17, PASSB 18.
REQ-012 SHALL encode lsu_opcode_o one-hot: LB b0, LH b1, LW b2, LBU b3, LHU b4, SB b5, SH b6, SW b7; 0 for non-memory instructions.
REQ-013 Per-class decode SHALL be:
- LUI: origin 01, PASSB, target 01.
- AUIPC: origin 10, ADD, target 01.
- OP-IMM/OP: origin 01/00, funct3/funct7 map to REQ-011; funct7=0000001 on OP selects the M-extension ops.
- Loads: origin 01, ADD, target 10.
- Stores: origin 01, ADD, target 00, mem_w_o=1.
REQ-014 Branch decode SHALL be:
- JAL: is_branch=1, is_condition=0, br_opcode 010, origin 10, ADD, target 11.
- JALR: br_opcode 011, origin 01, otherwise as JAL.
- BRANCH: is_branch=1, is_condition=1, br_opcode=funct3, origin 00, target 00.
REQ-015 SHALL assert reg_w_o only for data_target_o != 00 and rd != 0.
REQ-016 SYSTEM (opcode 1110011) SHALL set csr_opcode_o=funct3, csr_addr_o=instruction[31:20], origin 11, target 01 when funct3 != 0; for all other instructions csr_opcode_o and csr_addr_o SHALL be 0.
REQ-017 SHALL contain a 64-bit cycle counter (+1 every clk) and a 64-bit retired counter (+1 per decoded legal instruction); csr_data_o SHALL return 0xC00/0xB00 cycle[31:0], 0xC80/0xB80 cycle[63:32], 0xC02/0xB02 instret[31:0], 0xC82/0xB82 instret[63:32], and 0 for any other address; counters wrap modulo 2^64.
REQ-018 Illegal or unsupported opcode/funct combination SHALL produce an all-zero output bundle (no write, no branch, no memory) and SHALL NOT increment instret.

Reset
REQ-019 While reset=1, all outputs and both counters SHALL be 0, immediately (asynchronous).
REQ-020 First decode SHALL appear on the first rising edge after reset deasserts; reset mid-operation discards any pending decode.

Verification
REQ-021 0xabcde237 (lui x4) -> imm 0xABCDE000, rd 4, origin 01, alu 18, target 01, reg_w 1.
REQ-022 0x00c000ef (jal x1,12) -> imm 0x0000000C, rd 1, is_branch 1, is_condition 0, br 010, target 11.
REQ-023 0xfe001ee3 (bne) -> imm 0xFFFFFFFC, br 001, is_condition 1, reg_w 0; 0x00000263 (beq) -> imm 4, br 000.
REQ-024 0xb2e01203 (lh x4,-1234(x0)) -> imm 0xFFFFFB2E, lsu 0x02, target 10; 0x4c402923 (sw) -> imm 0x000004D2, rs2 4, lsu 0x80, mem_w 1, reg_w 0.
REQ-025 Reset held, then released; csrrs x5,0xC00,x0 -> csr_data_o equals cycles since reset release; csr_addr 0x123 -> 0.
REQ-026 0xFFFFFFFF (illegal) -> all outputs 0; rd=0 ALU instruction (0x00000013) -> reg_w 0.

Source files
------------

// File: rtl/rv32im_decoder_cu.sv
// rv32im_decoder_cu: registered RV32IM instruction decoder with cycle/instret counters
module rv32im_decoder_cu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [1:0]  data_origin_o,
    output logic [1:0]  data_target_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [4:0]  alu_opcode_o,
    output logic [7:0]  lsu_opcode_o,
    output logic [2:0]  br_opcode_o,
    output logic        is_branch_o,
    output logic        is_condition_o,
    output logic [2:0]  csr_opcode_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    output logic        mem_w_o,
    output logic        reg_w_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [1:0]  origin;
        logic [1:0]  target;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu;
        logic [7:0]  lsu;
        logic [2:0]  br;
        logic        is_branch;
        logic        is_cond;
        logic [2:0]  csr_op;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
        logic        mem_w;
        logic        reg_w;
    } bundle_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    bundle_t     d, q;
    logic [63:0] cycle_q, instret_q, cycle_n;

    assign opc   = instruction[6:0];
    assign f3    = instruction[14:12];
    assign f7    = instruction[31:25];
    assign imm_i = {{21{instruction[31]}}, instruction[30:20]};
    assign imm_s = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
    assign imm_b = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
    assign cycle_n = cycle_q + 64'd1;

    // base integer ALU op from funct3; alt selects SUB/SRA
    function automatic logic [4:0] alu_base(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu_base = alt ? 5'd1 : 5'd0;
            3'b001:  alu_base = 5'd2;
            3'b010:  alu_base = 5'd3;
            3'b011:  alu_base = 5'd4;
            3'b100:  alu_base = 5'd5;
            3'b101:  alu_base = alt ? 5'd7 : 5'd6;
            3'b110:  alu_base = 5'd8;
            default: alu_base = 5'd9;
        endcase
    endfunction

    // combinational decode of the current instruction word into the output bundle
    always_comb begin
        d       = '0;
        legal   = 1'b0;
        d.rs1   = instruction[19:15];
        d.rs2   = instruction[24:20];
        d.rd    = instruction[11:7];
        case (opc)
            OPC_LUI: begin
                legal    = 1'b1;
                d.imm    = imm_u;
                d.origin = 2'b01;
                d.alu    = 5'd18;
                d.target = 2'b01;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                d.imm    = imm_u;
                d.origin = 2'b10;
                d.target = 2'b01;
            end
            OPC_JAL: begin
                legal       = 1'b1;
                d.imm       = imm_j;
                d.origin    = 2'b10;
                d.target    = 2'b11;
                d.is_branch = 1'b1;
                d.br        = 3'b010;
            end
            OPC_JALR: begin
                legal       = f3 == 3'b000;
                d.imm       = imm_i;
                d.origin    = 2'b01;
                d.target    = 2'b11;
                d.is_branch = 1'b1;
                d.br        = 3'b011;
            end
            OPC_BRANCH: begin
                legal       = f3[2:1] != 2'b01;
                d.imm       = imm_b;
                d.is_branch = 1'b1;
                d.is_cond   = 1'b1;
                d.br        = f3;
            end
            OPC_LOAD: begin
                legal    = f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101;
                d.imm    = imm_i;
                d.origin = 2'b01;
                d.target = 2'b10;
                d.lsu    = {3'b000, f3 == 3'b101, f3 == 3'b100, f3 == 3'b010, f3 == 3'b001, f3 == 3'b000};
            end
            OPC_STORE: begin
                legal    = f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010;
                d.imm    = imm_s;
                d.origin = 2'b01;
                d.mem_w  = 1'b1;
                d.lsu    = {f3 == 3'b010, f3 == 3'b001, f3 == 3'b000, 5'b00000};
            end
            OPC_OPIMM: begin
                legal    = f3 == 3'b001 ? f7 == 7'b0000000 :
                           f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
                d.imm    = imm_i;
                d.origin = 2'b01;
                d.target = 2'b01;
                d.alu    = alu_base(f3, f3 == 3'b101 && f7[5]);
            end
            OPC_OP: begin
                legal    = f7 == 7'b0000000 || f7 == 7'b0000001 ||
                           (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                d.target = 2'b01;
                d.alu    = f7[0] ? 5'd10 + 5'(f3) : alu_base(f3, f7[5]);
            end
            OPC_SYSTEM: begin
                legal      = f3 != 3'b000;
                d.imm      = imm_i;
                d.origin   = 2'b11;
                d.target   = 2'b01;
                d.csr_op   = f3;
                d.csr_addr = instruction[31:20];
            end
            default: legal = 1'b0;
        endcase
        d.reg_w = d.target != 2'b00 && d.rd != 5'd0;
        // cycle reads include the current edge; instret reads exclude the instruction itself
        case (d.csr_addr)
            12'hC00, 12'hB00: d.csr_data = cycle_n[31:0];
            12'hC80, 12'hB80: d.csr_data = cycle_n[63:32];
            12'hC02, 12'hB02: d.csr_data = instret_q[31:0];
            12'hC82, 12'hB82: d.csr_data = instret_q[63:32];
            default:          d.csr_data = 32'h0;
        endcase
    end

    // output register; illegal words collapse to an all-zero bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= legal ? d : '0;
    end

    // free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            cycle_q   <= cycle_n;
            instret_q <= instret_q + 64'(legal);
        end
    end

    assign data_origin_o  = q.origin;
    assign data_target_o  = q.target;
    assign imm_o          = q.imm;
    assign rs1_addr_o     = q.rs1;
    assign rs2_addr_o     = q.rs2;
    assign rd_addr_o      = q.rd;
    assign alu_opcode_o   = q.alu;
    assign lsu_opcode_o   = q.lsu;
    assign br_opcode_o    = q.br;
    assign is_branch_o    = q.is_branch;
    assign is_condition_o = q.is_cond;
    assign csr_opcode_o   = q.csr_op;
    assign csr_addr_o     = q.csr_addr;
    assign csr_data_o     = q.csr_data;
    assign mem_w_o        = q.mem_w;
    assign reg_w_o        = q.reg_w;
endmodule

// File: tb/tb_rv32im_decoder_cu.sv
// tb_rv32im_decoder_cu: directed checks of the RV32IM decoder
module tb_rv32im_decoder_cu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic [1:0]  data_origin_o, data_target_o;
    logic [31:0] imm_o, csr_data_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o, alu_opcode_o;
    logic [7:0]  lsu_opcode_o;
    logic [2:0]  br_opcode_o, csr_opcode_o;
    logic        is_branch_o, is_condition_o, mem_w_o, reg_w_o;
    logic [11:0] csr_addr_o;
    int          checks = 0;
    int          errors = 0;

    rv32im_decoder_cu dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .data_origin_o(data_origin_o), .data_target_o(data_target_o), .imm_o(imm_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .alu_opcode_o(alu_opcode_o), .lsu_opcode_o(lsu_opcode_o), .br_opcode_o(br_opcode_o),
        .is_branch_o(is_branch_o), .is_condition_o(is_condition_o), .csr_opcode_o(csr_opcode_o),
        .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o), .mem_w_o(mem_w_o), .reg_w_o(reg_w_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] instr);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " bundle"}, {data_origin_o, data_target_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
            alu_opcode_o, lsu_opcode_o, br_opcode_o}, 64'h0);
        chk({tag, " flags"}, {is_branch_o, is_condition_o, csr_opcode_o, csr_addr_o, csr_data_o,
            mem_w_o, reg_w_o}, 64'h0);
    endtask

    initial begin
        instruction = 32'habcde237;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        apply(32'habcde237);
        chk("lui imm", imm_o, 32'hABCDE000);
        chk("lui rd", rd_addr_o, 5'd4);
        chk("lui origin", data_origin_o, 2'b01);
        chk("lui alu", alu_opcode_o, 5'd18);
        chk("lui target", data_target_o, 2'b01);
        chk("lui reg_w", reg_w_o, 1'b1);

        apply(32'h00c000ef);
        chk("jal imm", imm_o, 32'h0000000C);
        chk("jal rd", rd_addr_o, 5'd1);
        chk("jal br", {is_branch_o, is_condition_o, br_opcode_o}, 5'b10_010);
        chk("jal origin/target", {data_origin_o, data_target_o}, 4'b10_11);
        chk("jal reg_w", reg_w_o, 1'b1);

        apply(32'hfe001ee3);
        chk("bne imm", imm_o, 32'hFFFFFFFC);
        chk("bne br", {is_branch_o, is_condition_o, br_opcode_o}, 5'b11_001);
        chk("bne origin/target", {data_origin_o, data_target_o}, 4'b00_00);
        chk("bne reg_w", reg_w_o, 1'b0);

        apply(32'h00000263);
        chk("beq imm", imm_o, 32'h00000004);
        chk("beq br", br_opcode_o, 3'b000);

        apply(32'hb2e01203);
        chk("lh imm", imm_o, 32'hFFFFFB2E);
        chk("lh lsu", lsu_opcode_o, 8'h02);
        chk("lh target", data_target_o, 2'b10);
        chk("lh rd", rd_addr_o, 5'd4);

        apply(32'h4c402923);
        chk("sw imm", imm_o, 32'h000004D2);
        chk("sw rs2", rs2_addr_o, 5'd4);
        chk("sw lsu", lsu_opcode_o, 8'h80);
        chk("sw mem_w/reg_w", {mem_w_o, reg_w_o}, 2'b10);

        apply(32'h023100B3);
        chk("mul alu", alu_opcode_o, 5'd10);
        chk("mul regs", {rs1_addr_o, rs2_addr_o, rd_addr_o}, {5'd2, 5'd3, 5'd1});
        apply(32'h023150B3);
        chk("divu alu", alu_opcode_o, 5'd15);
        apply(32'h403100B3);
        chk("sub alu/origin", {alu_opcode_o, data_origin_o}, {5'd1, 2'b00});
        apply(32'h40315093);
        chk("srai alu/origin", {alu_opcode_o, data_origin_o}, {5'd7, 2'b01});
        apply(32'h00001097);
        chk("auipc", {data_origin_o, alu_opcode_o, data_target_o, imm_o}, {2'b10, 5'd0, 2'b01, 32'h00001000});
        apply(32'h004100E7);
        chk("jalr", {br_opcode_o, data_origin_o, data_target_o, imm_o}, {3'b011, 2'b01, 2'b11, 32'h4});

        apply(32'h00000013);
        chk("addi x0 target", data_target_o, 2'b01);
        chk("addi x0 reg_w", reg_w_o, 1'b0);

        apply(32'hFFFFFFFF);
        chk_zero("illegal");
        apply(32'h203100B3);
        chk_zero("bad funct7");

        apply(32'habcde237);
        reset = 1'b1;
        #1;
        chk_zero("async reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        instruction = 32'hC00022F3;
        repeat (5) @(posedge clk);
        #1;
        chk("csr cycle", csr_data_o, 32'd5);
        chk("csr op/addr", {csr_opcode_o, csr_addr_o}, {3'b010, 12'hC00});
        chk("csr origin/target/reg_w", {data_origin_o, data_target_o, reg_w_o}, 5'b11_01_1);

        apply(32'hC02022F3);
        chk("instret 5", csr_data_o, 32'd5);
        apply(32'hFFFFFFFF);
        chk("illegal csr_data", csr_data_o, 32'd0);
        apply(32'hC02022F3);
        chk("instret after illegal", csr_data_o, 32'd6);
        apply(32'h123022F3);
        chk("csr 0x123 data", csr_data_o, 32'd0);
        chk("csr 0x123 addr", csr_addr_o, 12'h123);
        apply(32'hC80022F3);
        chk("cycle hi", csr_data_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
